// File: rtl/wb_sram_arbiter_pkg.sv
// Shared types and constants for the Wishbone SRAM arbiter.
package wb_sram_arbiter_pkg;

    localparam int unsigned NUM_MASTERS = 3;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    // Round-robin pointer value that follows the given one-hot grant.
    function automatic logic [1:0] ptr_after(input logic [NUM_MASTERS-1:0] g);
        logic [1:0] p;
        case (g)
            3'b001:  p = 2'd1;
            3'b010:  p = 2'd2;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational 3-way round-robin priority encoder: first requester at or after pointer.
module wb_rr_pick (
    input  logic [2:0] request,
    input  logic [1:0] pointer,
    output logic [2:0] pick
);

    // Search order starts at pointer and wraps 0 -> 1 -> 2 -> 0.
    always_comb begin
        pick = 3'b000;
        case (pointer)
            2'd1: begin
                if (request[1])      pick = 3'b010;
                else if (request[2]) pick = 3'b100;
                else if (request[0]) pick = 3'b001;
            end
            2'd2: begin
                if (request[2])      pick = 3'b100;
                else if (request[0]) pick = 3'b001;
                else if (request[1]) pick = 3'b010;
            end
            default: begin
                if (request[0])      pick = 3'b001;
                else if (request[1]) pick = 3'b010;
                else if (request[2]) pick = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/wb_sram_arbiter.sv
// Three-master round-robin Wishbone arbiter in front of the shared SRAM controller.
module wb_sram_arbiter
    import wb_sram_arbiter_pkg::*;
#(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    input  logic        m2_cyc_i,
    input  logic        m2_stb_i,
    input  logic        m2_we_i,
    input  logic [31:0] m2_adr_i,
    input  logic [3:0]  m2_sel_i,
    input  logic [31:0] m2_dat_i,
    output logic [31:0] m2_dat_o,
    output logic        m2_ack_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    output logic [2:0]  grant_o
);

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(MAX_BURST);

    arb_state_e             state, state_nxt;
    logic [NUM_MASTERS-1:0] grant, grant_nxt;
    logic [1:0]             rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]       burst_cnt, burst_cnt_nxt, cnt_inc;
    logic [NUM_MASTERS-1:0] req, pick;
    logic                   limit_hit;

    logic        sel_cyc, sel_stb, sel_we;
    logic [31:0] sel_adr, sel_dat;
    logic [3:0]  sel_sel;

    assign req = {m2_cyc_i, m1_cyc_i, m0_cyc_i};

    wb_rr_pick u_pick (
        .request (req),
        .pointer (rr_ptr),
        .pick    (pick)
    );

    // Route the granted master's request fields towards the slave.
    always_comb begin
        sel_cyc = 1'b0;
        sel_stb = 1'b0;
        sel_we  = 1'b0;
        sel_adr = '0;
        sel_sel = '0;
        sel_dat = '0;
        case (grant)
            3'b001: begin
                sel_cyc = m0_cyc_i; sel_stb = m0_stb_i; sel_we = m0_we_i;
                sel_adr = m0_adr_i; sel_sel = m0_sel_i; sel_dat = m0_dat_i;
            end
            3'b010: begin
                sel_cyc = m1_cyc_i; sel_stb = m1_stb_i; sel_we = m1_we_i;
                sel_adr = m1_adr_i; sel_sel = m1_sel_i; sel_dat = m1_dat_i;
            end
            3'b100: begin
                sel_cyc = m2_cyc_i; sel_stb = m2_stb_i; sel_we = m2_we_i;
                sel_adr = m2_adr_i; sel_sel = m2_sel_i; sel_dat = m2_dat_i;
            end
            default: ;
        endcase
    end

    assign limit_hit = (MAX_BURST != 0) && (burst_cnt >= BURST_LIM);

    // Reset gates every control and ack so an aborted transfer never reaches either side.
    assign s_cyc_o  = sel_cyc & ~reset;
    assign s_stb_o  = sel_stb & ~limit_hit & ~reset;
    assign s_we_o   = sel_we & ~reset;
    assign s_adr_o  = sel_adr;
    assign s_sel_o  = sel_sel;
    assign s_dat_o  = sel_dat;
    assign m0_ack_o = s_ack_i & grant[0] & ~reset;
    assign m1_ack_o = s_ack_i & grant[1] & ~reset;
    assign m2_ack_o = s_ack_i & grant[2] & ~reset;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;
    assign m2_dat_o = s_dat_i;
    assign grant_o  = grant;

    // Next-state: grant from IDLE, count acks and release in OWN, one dead cycle in GAP.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        cnt_inc       = (burst_cnt == {CNT_W{1'b1}}) ? burst_cnt : CNT_W'(burst_cnt + 1'b1);
        case (state)
            ST_IDLE: begin
                if (|req) begin
                    grant_nxt     = pick;
                    burst_cnt_nxt = '0;
                    state_nxt     = ST_OWN;
                end
            end
            ST_OWN: begin
                if (s_ack_i) begin
                    burst_cnt_nxt = cnt_inc;
                end
                if ((s_ack_i && (MAX_BURST != 0) && (cnt_inc == BURST_LIM)) ||
                    (!sel_cyc && !s_ack_i)) begin
                    grant_nxt  = '0;
                    rr_ptr_nxt = ptr_after(grant);
                    state_nxt  = ST_GAP;
                end
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and burst counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= 2'd0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// Directed bench for wb_sram_arbiter: instance 0 MAX_BURST=16, 1 MAX_BURST=1, 2 MAX_BURST=0.
`timescale 1ns/1ps
module tb_wb_sram_arbiter;

    localparam int unsigned NK = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m_cyc  [NK][3];
    logic        m_stb  [NK][3];
    logic        m_we   [NK][3];
    logic [31:0] m_adr  [NK][3];
    logic [3:0]  m_sel  [NK][3];
    logic [31:0] m_wdat [NK][3];
    logic [31:0] m_rdat [NK][3];
    logic        m_ack  [NK][3];
    logic        s_cyc  [NK];
    logic        s_stb  [NK];
    logic        s_we   [NK];
    logic [31:0] s_adr  [NK];
    logic [3:0]  s_sel  [NK];
    logic [31:0] s_wdat [NK];
    logic [31:0] s_rdat [NK];
    logic        s_ack  [NK];
    logic [2:0]  grant  [NK];

    for (genvar k = 0; k < NK; k++) begin : g_dut
        wb_sram_arbiter #(.MAX_BURST((k == 0) ? 16 : ((k == 1) ? 1 : 0))) dut (
            .clk(clk), .reset(reset),
            .m0_cyc_i(m_cyc[k][0]), .m0_stb_i(m_stb[k][0]), .m0_we_i(m_we[k][0]),
            .m0_adr_i(m_adr[k][0]), .m0_sel_i(m_sel[k][0]), .m0_dat_i(m_wdat[k][0]),
            .m0_dat_o(m_rdat[k][0]), .m0_ack_o(m_ack[k][0]),
            .m1_cyc_i(m_cyc[k][1]), .m1_stb_i(m_stb[k][1]), .m1_we_i(m_we[k][1]),
            .m1_adr_i(m_adr[k][1]), .m1_sel_i(m_sel[k][1]), .m1_dat_i(m_wdat[k][1]),
            .m1_dat_o(m_rdat[k][1]), .m1_ack_o(m_ack[k][1]),
            .m2_cyc_i(m_cyc[k][2]), .m2_stb_i(m_stb[k][2]), .m2_we_i(m_we[k][2]),
            .m2_adr_i(m_adr[k][2]), .m2_sel_i(m_sel[k][2]), .m2_dat_i(m_wdat[k][2]),
            .m2_dat_o(m_rdat[k][2]), .m2_ack_o(m_ack[k][2]),
            .s_cyc_o(s_cyc[k]), .s_stb_o(s_stb[k]), .s_we_o(s_we[k]),
            .s_adr_o(s_adr[k]), .s_sel_o(s_sel[k]), .s_dat_o(s_wdat[k]),
            .s_dat_i(s_rdat[k]), .s_ack_i(s_ack[k]), .grant_o(grant[k])
        );
    end

    // Slave model: ack the cycle after a strobe, never two acks back to back.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NK; k++)
            s_ack[k] <= reset ? 1'b0 : (s_cyc[k] & s_stb[k] & ~s_ack[k]);
    end

    // Slave read data: fixed word at 0x100, inverted address elsewhere.
    always_comb begin
        for (int k = 0; k < NK; k++)
            s_rdat[k] = (s_adr[k] == 32'h100) ? 32'hDEADBEEF : ~s_adr[k];
    end

    int          total, bad;
    int          rem    [NK][3];
    bit          auto_m [NK][3];
    logic        sn_ack [NK][3];
    logic [31:0] sn_rdat[NK][3];
    logic [2:0]  sn_gnt [NK];
    logic        sn_cyc [NK];
    logic        sn_stb [NK];
    logic        sn_we  [NK];
    logic [31:0] sn_adr [NK];
    logic [3:0]  sn_sel [NK];
    logic [31:0] sn_wdat[NK];

    task automatic drive_all();
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < 3; i++)
                if (auto_m[k][i]) begin
                    m_cyc[k][i] = (rem[k][i] > 0);
                    m_stb[k][i] = (rem[k][i] > 0);
                end
    endtask

    // One bus cycle: sample mid-cycle, then let auto masters react after the edge.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NK; k++) begin
            sn_gnt[k] = grant[k]; sn_cyc[k] = s_cyc[k]; sn_stb[k] = s_stb[k];
            sn_we[k] = s_we[k]; sn_adr[k] = s_adr[k]; sn_sel[k] = s_sel[k];
            sn_wdat[k] = s_wdat[k];
            for (int i = 0; i < 3; i++) begin
                sn_ack[k][i] = m_ack[k][i];
                sn_rdat[k][i] = m_rdat[k][i];
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < 3; i++)
                if (auto_m[k][i] && sn_ack[k][i] && rem[k][i] > 0) rem[k][i]--;
        drive_all();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rem[0][0] = 1;
        drive_all();
        step();
        step();
        for (int k = 0; k < NK; k++) begin
            total++;
            if (sn_gnt[k] !== 3'b000 || sn_cyc[k] !== 1'b0 || sn_stb[k] !== 1'b0 ||
                sn_ack[k][0] !== 1'b0 || sn_ack[k][1] !== 1'b0 || sn_ack[k][2] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state inst%0d: grant=%b cyc=%b stb=%b want 000/0/0 no ack",
                         k, sn_gnt[k], sn_cyc[k], sn_stb[k]);
            end
        end
        rem[0][0] = 0;
        drive_all();
        reset = 1'b0;
        step();
        total++;
        if (sn_gnt[0] !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: grant=%b want 000", sn_gnt[0]);
        end
    endtask

    task automatic test_single_read();
        int acks;
        acks = 0;
        m_adr[0][0] = 32'h100;
        rem[0][0] = 1;
        drive_all();
        step();
        total++;
        if (sn_stb[0] !== 1'b0 || sn_gnt[0] !== 3'b000) begin
            bad++;
            $display("FAIL read_c0: stb=%b grant=%b want 0/000", sn_stb[0], sn_gnt[0]);
        end
        step();
        total++;
        if (sn_gnt[0] !== 3'b001 || sn_stb[0] !== 1'b1 || sn_adr[0] !== 32'h100 || sn_ack[0][0] !== 1'b0) begin
            bad++;
            $display("FAIL read_c1: grant=%b stb=%b adr=%h ack=%b want 001/1/100/0",
                     sn_gnt[0], sn_stb[0], sn_adr[0], sn_ack[0][0]);
        end
        step();
        total++;
        if (sn_ack[0][0] !== 1'b1 || sn_rdat[0][0] !== 32'hDEADBEEF ||
            sn_ack[0][1] !== 1'b0 || sn_ack[0][2] !== 1'b0) begin
            bad++;
            $display("FAIL read_c2: ack=%b%b%b dat=%h want ack 001 dat deadbeef",
                     sn_ack[0][2], sn_ack[0][1], sn_ack[0][0], sn_rdat[0][0]);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            if (sn_ack[0][0] === 1'b1) acks++;
        end
        total++;
        if (acks != 0 || sn_gnt[0] !== 3'b000 || rem[0][0] != 0) begin
            bad++;
            $display("FAIL read_done: extra_acks=%0d grant=%b want 0/000", acks, sn_gnt[0]);
        end
        m_adr[0][0] = 32'h1000;
    endtask

    task automatic test_write_routing();
        m_adr[0][0] = 32'h200; m_we[0][0] = 1'b1; m_sel[0][0] = 4'b0011; m_wdat[0][0] = 32'h12345678;
        rem[0][0] = 1;
        drive_all();
        step();
        step();
        total++;
        if (sn_gnt[0] !== 3'b001 || sn_we[0] !== 1'b1 || sn_sel[0] !== 4'b0011 ||
            sn_wdat[0] !== 32'h12345678 || sn_adr[0] !== 32'h200) begin
            bad++;
            $display("FAIL write_route: grant=%b we=%b sel=%b dat=%h adr=%h want 001/1/0011/12345678/200",
                     sn_gnt[0], sn_we[0], sn_sel[0], sn_wdat[0], sn_adr[0]);
        end
        step();
        total++;
        if (sn_ack[0][0] !== 1'b1 || sn_ack[0][1] !== 1'b0 || sn_ack[0][2] !== 1'b0) begin
            bad++;
            $display("FAIL write_ack: ack=%b%b%b want 001", sn_ack[0][2], sn_ack[0][1], sn_ack[0][0]);
        end
        repeat (3) step();
        m_adr[0][0] = 32'h1000; m_we[0][0] = 1'b0; m_sel[0][0] = 4'hF; m_wdat[0][0] = '0;
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g [4];
        logic [2:0] prev_g;
        logic       prev_cyc;
        int         ep, n;
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
        prev_g = 3'b000; prev_cyc = 1'b0; ep = 0;
        for (int i = 0; i < 3; i++) rem[1][i] = 3;
        drive_all();
        for (n = 0; n < 120; n++) begin
            step();
            total++;
            if (!$onehot0(sn_gnt[1]) || (sn_gnt[1] == 3'b000 && sn_stb[1] !== 1'b0)) begin
                bad++;
                $display("FAIL rr_safety: grant=%b stb=%b", sn_gnt[1], sn_stb[1]);
            end
            if (sn_gnt[1] != 3'b000 && prev_g == 3'b000) begin
                if (ep < 4) begin
                    total++;
                    if (sn_gnt[1] !== exp_g[ep] || prev_cyc !== 1'b0) begin
                        bad++;
                        $display("FAIL rr_grant%0d: grant=%b prev_cyc=%b want %b/0",
                                 ep, sn_gnt[1], prev_cyc, exp_g[ep]);
                    end
                end
                ep++;
            end
            prev_g = sn_gnt[1];
            prev_cyc = sn_cyc[1];
            if (rem[1][0] == 0 && rem[1][1] == 0 && rem[1][2] == 0 && sn_gnt[1] == 3'b000) break;
        end
        total++;
        if (n == 120 || ep != 9) begin
            bad++;
            $display("FAIL rr_complete: episodes=%0d cycles=%0d want 9 within 120", ep, n);
        end
    endtask

    task automatic test_burst_limit();
        logic [2:0] ep_g   [8];
        int         ep_cnt [8];
        logic [2:0] prev_g;
        int         ep, n, a0, a2;
        prev_g = 3'b000; ep = -1; a0 = 0; a2 = 0;
        for (int e = 0; e < 8; e++) begin ep_g[e] = 3'b000; ep_cnt[e] = 0; end
        rem[0][2] = 40;
        rem[0][0] = 2;
        drive_all();
        for (n = 0; n < 400; n++) begin
            step();
            if (sn_gnt[0] != 3'b000 && prev_g == 3'b000 && ep < 7) begin
                ep++;
                ep_g[ep] = sn_gnt[0];
            end
            if (ep >= 0 && (sn_ack[0][0] || sn_ack[0][1] || sn_ack[0][2])) ep_cnt[ep]++;
            if (sn_ack[0][0] === 1'b1) a0++;
            if (sn_ack[0][2] === 1'b1) a2++;
            prev_g = sn_gnt[0];
            if (rem[0][0] == 0 && rem[0][2] == 0 && sn_gnt[0] == 3'b000) break;
        end
        total++;
        if (ep_g[0] !== 3'b100 || ep_cnt[0] != 16) begin
            bad++;
            $display("FAIL burst_first: grant=%b acks=%0d want 100/16", ep_g[0], ep_cnt[0]);
        end
        total++;
        if (ep_g[1] !== 3'b001 || ep_cnt[1] != 2) begin
            bad++;
            $display("FAIL burst_handover: grant=%b acks=%0d want 001/2", ep_g[1], ep_cnt[1]);
        end
        total++;
        if (ep_g[2] !== 3'b100 || ep_cnt[2] != 16 || ep_g[3] !== 3'b100 || ep_cnt[3] != 8) begin
            bad++;
            $display("FAIL burst_resume: g2=%b n2=%0d g3=%b n3=%0d want 100/16 100/8",
                     ep_g[2], ep_cnt[2], ep_g[3], ep_cnt[3]);
        end
        total++;
        if (n == 400 || a2 != 40 || a0 != 2) begin
            bad++;
            $display("FAIL burst_totals: m2=%0d m0=%0d cycles=%0d want 40/2", a2, a0, n);
        end
    endtask

    task automatic test_bus_lock();
        logic [15:0] cyc_pat, stb_pat;
        int          a1, early0, held;
        cyc_pat = 16'b0000_0111_1111_1111;
        stb_pat = 16'b0000_0011_0110_0110;
        a1 = 0; early0 = 0; held = 0;
        auto_m[2][1] = 1'b0;
        for (int c = 0; c < 19; c++) begin
            m_cyc[2][1] = cyc_pat[c];
            m_stb[2][1] = stb_pat[c];
            if (c == 3) begin
                rem[2][0] = 1;
                drive_all();
            end
            step();
            if (sn_ack[2][1] === 1'b1) a1++;
            if (c < 14 && sn_ack[2][0] === 1'b1) early0++;
            if (c >= 1 && c <= 11 && sn_gnt[2] === 3'b010) held++;
            if (c == 14) begin
                total++;
                if (sn_gnt[2] !== 3'b001) begin
                    bad++;
                    $display("FAIL lock_next_owner: grant=%b want 001", sn_gnt[2]);
                end
            end
        end
        total++;
        if (held != 11) begin
            bad++;
            $display("FAIL lock_held: cycles_with_010=%0d want 11", held);
        end
        total++;
        if (a1 != 3 || early0 != 0) begin
            bad++;
            $display("FAIL lock_acks: m1=%0d early_m0=%0d want 3/0", a1, early0);
        end
        total++;
        if (rem[2][0] != 0) begin
            bad++;
            $display("FAIL lock_m0_served: remaining=%0d want 0", rem[2][0]);
        end
        auto_m[2][1] = 1'b1;
        drive_all();
    endtask

    task automatic test_reset_mid_transfer();
        int n;
        rem[0][2] = 1;
        drive_all();
        step();
        reset = 1'b1;
        rem[0][1] = 1;
        drive_all();
        step();
        total++;
        if (sn_cyc[0] !== 1'b0 || sn_stb[0] !== 1'b0 || sn_ack[0][2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_gate: cyc=%b stb=%b ack2=%b want 0/0/0", sn_cyc[0], sn_stb[0], sn_ack[0][2]);
        end
        reset = 1'b0;
        step();
        total++;
        if (sn_gnt[0] !== 3'b000 || sn_cyc[0] !== 1'b0 ||
            sn_ack[0][0] !== 1'b0 || sn_ack[0][1] !== 1'b0 || sn_ack[0][2] !== 1'b0) begin
            bad++;
            $display("FAIL rst_abort: grant=%b cyc=%b want 000/0 no ack", sn_gnt[0], sn_cyc[0]);
        end
        step();
        total++;
        if (sn_gnt[0] !== 3'b010) begin
            bad++;
            $display("FAIL rst_regrant: grant=%b want 010", sn_gnt[0]);
        end
        for (n = 0; n < 30; n++) begin
            step();
            if (rem[0][1] == 0 && rem[0][2] == 0 && sn_gnt[0] == 3'b000) break;
        end
        total++;
        if (n == 30) begin
            bad++;
            $display("FAIL rst_drain: m1_rem=%0d m2_rem=%0d want 0/0", rem[0][1], rem[0][2]);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        for (int k = 0; k < NK; k++)
            for (int i = 0; i < 3; i++) begin
                rem[k][i]    = 0;
                auto_m[k][i] = 1'b1;
                m_cyc[k][i]  = 1'b0;
                m_stb[k][i]  = 1'b0;
                m_we[k][i]   = 1'b0;
                m_adr[k][i]  = 32'h1000 + 32'(i) * 32'h100;
                m_sel[k][i]  = 4'hF;
                m_wdat[k][i] = '0;
            end
        @(posedge clk);
        #1;
        test_reset();
        test_single_read();
        test_write_routing();
        test_round_robin();
        test_burst_limit();
        test_bus_lock();
        test_reset_mid_transfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_sram_arbiter.md
Name: wb_sram_arbiter

Overview:
- Shares one Wishbone slave (the 32-bit SRAM controller) between three Wishbone masters: m0 = CPU data, m1 = CPU instruction, m2 = LED frame scanout.
- Round-robin arbitration with registered grant; the granted master owns the slave until it drops cyc or exhausts its burst budget.
- Sits between the masters and the SRAM controller. Adds one cycle of arbitration latency per grant and none per transfer.

Parameters:
- MAX_BURST, 16, acknowledged transfers allowed per grant before forced release; 0 = unlimited; range 0..255.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high
- mN_cyc_i  input  1  master N cycle (N = 0..2; one port per master)
- mN_stb_i  input  1  master N strobe
- mN_we_i  input  1  master N write enable
- mN_adr_i  input  32  master N byte address
- mN_sel_i  input  4  master N byte selects
- mN_dat_i  input  32  master N write data
- mN_dat_o  output  32  read data to master N
- mN_ack_o  output  1  acknowledge to master N
- s_cyc_o, s_stb_o, s_we_o  output  1 each  to slave
- s_adr_o  output  32  to slave
- s_sel_o  output  4  to slave
- s_dat_o  output  32  to slave
- s_dat_i  input  32  from slave
- s_ack_i  input  1  from slave
- grant_o  output  3  one-hot current grant (debug/perf counters)

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset values: grant = 000, state = IDLE, rr pointer = 0, burst counter = 0.
- In reset, all s_* controls and all mN_ack_o are 0. s_adr_o, s_sel_o, s_dat_o and all mN_dat_o are don't-care.
- States:
  - IDLE: no grant.
  - OWN: exactly one grant bit set.
  - GAP: one cycle with no grant, entered after every release.
- IDLE: a request is mN_cyc_i = 1. If any master requests, pick the first requester at or after the rr pointer (order 0→1→2→0). Set grant on the next edge, clear the burst counter, go to OWN.
  - So a request at cycle 0 gives slave stb at cycle 1 at the earliest.
- OWN, signal routing:
  - s_cyc/stb/we/adr/sel/dat_o are muxed combinationally from the granted master.
  - s_stb_o is additionally forced 0 once the burst limit is reached.
  - mN_ack_o = s_ack_i & grant[N].
  - Read data s_dat_i is broadcast to all mN_dat_o; only the granted master sees ack.
- OWN, counting and release:
  - Each s_ack_i increments the burst counter (saturating at 255).
  - Release when the granted cyc_i = 0 in a cycle with no pending ack.
  - Also release when the counter reaches MAX_BURST (MAX_BURST ≠ 0) on an ack edge.
  - On release: clear grant, set rr pointer = granted index + 1 mod 3, go to GAP.
- GAP → IDLE unconditionally. This guarantees s_cyc_o is low for at least one cycle between owners, and lets the slave's own ack-low cycle elapse.
- Forced release: the master keeps cyc/stb high and is simply stalled (no ack) until re-granted. If it is the only requester, it is re-granted after GAP + IDLE (2 cycles).
- A master that drops stb but holds cyc keeps ownership (bus lock). The burst limit still applies.
- Simultaneous events:
  - Ack and cyc drop in the same cycle: the ack is delivered, then release.
  - New requests during OWN/GAP wait for IDLE.
- Reset mid-transfer aborts immediately: the grant is dropped and no ack is forwarded. The SRAM controller shares the same reset.
- Safety: exactly one or zero grant bits at all times. No transfer reaches the slave while grant = 000.

Decomposition:
- No package needed. Local constants: state encodings, NUM_MASTERS = 3.
- One natural sub-module: wb_rr_pick, a combinational 3-way round-robin priority encoder (inputs request[2:0] and pointer[1:0], output one-hot pick). Reusable by other arbiters in the design.

Test Plan:
- Single read: m0 requests a read at adr 0x100 with the slave returning 0xDEADBEEF → s_stb_o rises cycle 1, m0_ack_o pulses once with m0_dat_o = 0xDEADBEEF, m1/m2 acks stay 0.
- Round robin: all three request continuously with MAX_BURST = 1 → grant sequence 001, 010, 100, 001, each grant separated by ≥1 cycle with s_cyc_o = 0.
- Burst limit: m2 holds cyc for 40 reads with MAX_BURST = 16 while m0 is also requesting → m2 gets 16 acks, then m0 is granted; m2 resumes after m0 releases; total m2 acks = 40.
- Bus lock: m1 holds cyc, stb pulses 3 times with idle gaps, MAX_BURST = 0 → grant stays 010 throughout; m0 is only granted after m1 cyc drops.
- Write routing: m0 writes 0x12345678 with sel 0011 → s_we_o = 1, s_sel_o = 0011, s_dat_o = 0x12345678; no other master is acked.
- Reset mid-transfer: assert reset during an m2 OWN read before the ack → next cycle grant_o = 000, s_cyc_o = 0, no mN_ack_o; after reset releases, a pending m1 request is granted first (rr pointer = 0 skips idle m0).
